// File: rtl/dcache_pkg.sv
// Shared constants, FSM encodings and address field helpers for the L1 data cache.
package dcache_pkg;

  localparam int DC_ADDR_W    = 32;
  localparam int DC_LINES     = 32;
  localparam int DC_BLOCK_W   = 256;
  localparam int WORD_W       = 32;
  localparam int TAG_W        = 22;
  localparam int IDX_W        = 5;
  localparam int OFS_W        = 5;
  localparam int WORD_SEL_W   = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WRITEBACK = 2'd1;
  localparam state_t ST_ALLOCATE  = 2'd2;
  localparam state_t ST_REFILL    = 2'd3;

  // Tag is everything above the index and block offset.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [DC_ADDR_W-1:0] addr);
    return TAG_W'(addr >> (OFS_W + IDX_W));
  endfunction

  // Line index sits directly above the 32-byte block offset.
  function automatic logic [IDX_W-1:0] addr_index(input logic [DC_ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFS_W);
  endfunction

  // Word within the line; the byte-in-word bits are dropped.
  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [DC_ADDR_W-1:0] addr);
    return WORD_SEL_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// Reads are combinational by index; writes are a full-line fill or a single-word merge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES   = DC_LINES,
  parameter int BLOCK_W = DC_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               word_en,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]  word_data,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data
);

  logic [LINES-1:0]   valid_r;
  logic [LINES-1:0]   dirty_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [BLOCK_W-1:0] data_r [LINES];

  // Status bits: cleared by reset, a fill makes the line valid and clean, a word store dirties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fill_en) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_r[idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_r[idx]  <= fill_tag;
      data_r[idx] <= fill_data;
    end else if (word_en) begin
      data_r[idx][{word_sel, 5'b00000} +: WORD_W] <= word_data;
    end
  end

  // Combinational read port for the currently addressed line.
  always_comb begin
    rd_valid = valid_r[idx];
    rd_dirty = dirty_r[idx];
    rd_tag   = tag_r[idx];
    rd_data  = data_r[idx];
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits finish in the access cycle; misses stall the pipeline through an
// optional write-back of the dirty victim and a block refill.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES   = DC_LINES,
  parameter int BLOCK_W = DC_BLOCK_W,
  parameter int ADDR_W  = DC_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [31:0]        cpu_wdata_i,
  output logic [31:0]        cpu_rdata_o,
  output logic               cpu_stall_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i
);

  state_t                 state_r;
  state_t                 next_state_s;

  logic [TAG_W-1:0]       req_tag_s;
  logic [IDX_W-1:0]       req_idx_s;
  logic [WORD_SEL_W-1:0]  req_word_s;

  logic                   line_valid_s;
  logic                   line_dirty_s;
  logic [TAG_W-1:0]       line_tag_s;
  logic [BLOCK_W-1:0]     line_data_s;

  logic                   hit_s;
  logic                   miss_s;
  logic [31:0]            sel_word_s;
  logic                   fill_en_s;
  logic                   word_en_s;

  // Address decode and hit detection against the indexed line.
  always_comb begin
    req_tag_s  = addr_tag(cpu_addr_i);
    req_idx_s  = addr_index(cpu_addr_i);
    req_word_s = addr_word(cpu_addr_i);
    hit_s      = cpu_req_i & line_valid_s & (line_tag_s == req_tag_s);
    miss_s     = cpu_req_i & ~hit_s;
    sel_word_s = line_data_s[{req_word_s, 5'b00000} +: 32];
  end

  // Array write enables; reset at the same edge wins so an abandoned refill never lands.
  always_comb begin
    fill_en_s = (state_r == ST_ALLOCATE) & mem_ack_i & ~rst_i;
    word_en_s = ((state_r == ST_IDLE) | (state_r == ST_REFILL)) & hit_s & cpu_we_i & ~rst_i;
  end

  dcache_sram #(
    .LINES   (LINES),
    .BLOCK_W (BLOCK_W)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (req_idx_s),
    .fill_en   (fill_en_s),
    .fill_tag  (req_tag_s),
    .fill_data (mem_rdata_i),
    .word_en   (word_en_s),
    .word_sel  (req_word_s),
    .word_data (cpu_wdata_i),
    .rd_valid  (line_valid_s),
    .rd_dirty  (line_dirty_s),
    .rd_tag    (line_tag_s),
    .rd_data   (line_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: a dirty victim is written back before the refill.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          if (line_valid_s && line_dirty_s) begin
            next_state_s = ST_WRITEBACK;
          end else begin
            next_state_s = ST_ALLOCATE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) begin
          next_state_s = ST_ALLOCATE;
        end else begin
          next_state_s = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        if (mem_ack_i) begin
          next_state_s = ST_REFILL;
        end else begin
          next_state_s = ST_ALLOCATE;
        end
      end
      ST_REFILL: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // CPU and memory interface outputs decoded from state and the current lookup.
  always_comb begin
    cpu_rdata_o = 32'h0000_0000;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_wdata_o = {BLOCK_W{1'b0}};
    case (state_r)
      ST_IDLE, ST_REFILL: begin
        // REFILL replays the access, which is now guaranteed to hit.
        if (hit_s && !cpu_we_i) begin
          cpu_rdata_o = sel_word_s;
        end else begin
          cpu_rdata_o = 32'h0000_0000;
        end
        if (state_r == ST_IDLE) begin
          cpu_stall_o = miss_s;
        end else begin
          cpu_stall_o = 1'b0;
        end
      end
      ST_WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {line_tag_s, req_idx_s, 5'b00000};
        mem_wdata_o = line_data_s;
      end
      ST_ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b0;
        mem_addr_o  = {req_tag_s, req_idx_s, 5'b00000};
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Table-driven bench for dcache_controller with a latency-programmable memory model,
// a reference word store for expected load data, and hand-written reset sequences.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = 32'h0;
  logic [31:0]  cpu_wdata_i = 32'h0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = 256'h0;
  logic         mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic        wb;
    logic [31:0] wb_addr;
    logic        al;
    logic [31:0] al_addr;
  } vec_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  int n_vec = 0;
  int n_bad = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  bit mem_auto = 1'b1;
  bit stray_ack = 1'b0;

  bit [31:0] ref_words [bit [31:0]];
  bit [31:0] mem_words [bit [31:0]];
  logic [31:0] exp_q [$];
  txn_t        txn_q [$];

  vec_t vt [15];

  function automatic bit [31:0] pat(input bit [31:0] wa);
    return wa ^ 32'h5A5A_0000;
  endfunction

  function automatic bit [31:0] ref_read(input bit [31:0] a);
    bit [31:0] wa;
    wa = {a[31:2], 2'b00};
    return ref_words.exists(wa) ? ref_words[wa] : pat(wa);
  endfunction

  function automatic logic [255:0] ref_block(input bit [31:0] ba);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = ref_read(ba + 32'(w * 4));
    return b;
  endfunction

  function automatic logic [255:0] mem_block(input bit [31:0] ba);
    logic [255:0] b;
    bit [31:0] wa;
    for (int w = 0; w < 8; w++) begin
      wa = ba + 32'(w * 4);
      b[w*32 +: 32] = mem_words.exists(wa) ? mem_words[wa] : pat(wa);
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks after mem_lat waiting cycles, logs every completed transaction.
  always @(negedge clk_i) begin
    if (!mem_auto) begin
      mem_cnt = 0;
      mem_ack_i = stray_ack;
      if (stray_ack) mem_rdata_i = {256{1'b1}};
    end else begin
      mem_ack_i = 1'b0;
      if (!mem_req_o) begin
        mem_cnt = 0;
      end else if (mem_cnt >= mem_lat) begin
        mem_ack_i = 1'b1;
        mem_cnt = 0;
        txn_q.push_back('{we: mem_we_o, addr: mem_addr_o, data: mem_wdata_o});
        if (mem_we_o) begin
          for (int w = 0; w < 8; w++) mem_words[mem_addr_o + 32'(w * 4)] = mem_wdata_o[w*32 +: 32];
        end else begin
          mem_rdata_i = mem_block(mem_addr_o);
        end
      end else begin
        mem_cnt++;
      end
    end
  end

  task automatic do_access(input vec_t v);
    int stalls;
    int reqs;
    int ntx;
    txn_t t;
    logic [31:0] e;
    @(posedge clk_i); #1;
    mem_lat     = v.lat;
    cpu_req_i   = 1'b1;
    cpu_we_i    = v.we;
    cpu_addr_i  = v.addr;
    cpu_wdata_i = v.wdata;
    if (v.we) ref_words[{v.addr[31:2], 2'b00}] = v.wdata;
    else exp_q.push_back(ref_read(v.addr));
    stalls = 0;
    reqs = 0;
    @(negedge clk_i);
    while (cpu_stall_o === 1'b1 && stalls < 100) begin
      stalls++;
      if (mem_req_o === 1'b1) reqs++;
      @(negedge clk_i);
    end
    if (mem_req_o !== 1'b0) reqs++;
    chk($sformatf("stall_cycles@%0h", v.addr), stalls, v.exp_stall);
    chk($sformatf("memreq_cycles@%0h", v.addr), reqs, (v.exp_stall == 0) ? 0 : v.exp_stall - 1);
    if (!v.we) begin
      e = exp_q.pop_front();
      chk($sformatf("load_data@%0h", v.addr), cpu_rdata_o, e);
    end
    ntx = int'(v.wb) + int'(v.al);
    chk($sformatf("txn_count@%0h", v.addr), txn_q.size(), ntx);
    if (v.wb && txn_q.size() > 0) begin
      t = txn_q.pop_front();
      chk("wb_we", t.we, 1'b1);
      chk("wb_addr", t.addr, v.wb_addr);
      chk("wb_data", t.data, ref_block(v.wb_addr));
    end
    if (v.al && txn_q.size() > 0) begin
      t = txn_q.pop_front();
      chk("al_we", t.we, 1'b0);
      chk("al_addr", t.addr, v.al_addr);
    end
    txn_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, cpu_stall_o, 1'b0);
    chk({tag, "_memreq"}, mem_req_o, 1'b0);
    chk({tag, "_memwe"}, mem_we_o, 1'b0);
    chk({tag, "_memaddr"}, mem_addr_o, 32'h0);
    chk({tag, "_memwdata"}, mem_wdata_o, 256'h0);
    chk({tag, "_rdata"}, cpu_rdata_o, 32'h0);
  endtask

  initial begin
    ref_words[32'h44] = 32'hDEAD_BEEF;
    mem_words[32'h44] = 32'hDEAD_BEEF;

    //          we    addr         wdata         lat stall wb    wb_addr     al    al_addr
    vt[0]  = '{1'b0, 32'h0000_0040, 32'h0,         3, 5, 1'b0, 32'h0,   1'b1, 32'h040};
    vt[1]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[2]  = '{1'b0, 32'h0000_0044, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h0000_0444, 32'h0,         0, 3, 1'b1, 32'h040, 1'b1, 32'h440};
    vt[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1, 3, 1'b0, 32'h0,   1'b1, 32'h100};
    vt[5]  = '{1'b0, 32'h0000_0124, 32'h0,         2, 4, 1'b0, 32'h0,   1'b1, 32'h120};
    vt[6]  = '{1'b0, 32'h0000_0148, 32'h0,         0, 2, 1'b0, 32'h0,   1'b1, 32'h140};
    vt[7]  = '{1'b0, 32'h0000_016C, 32'h0,         1, 3, 1'b0, 32'h0,   1'b1, 32'h160};
    vt[8]  = '{1'b0, 32'h0000_0104, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0000_0120, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h0000_014C, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[11] = '{1'b0, 32'h0000_0168, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[12] = '{1'b1, 32'h0000_0088, 32'hCAFE_F00D, 1, 3, 1'b0, 32'h0,   1'b1, 32'h080};
    vt[13] = '{1'b0, 32'h0000_0088, 32'h0,         0, 0, 1'b0, 32'h0,   1'b0, 32'h0};
    vt[14] = '{1'b0, 32'h0000_0488, 32'h0,         0, 3, 1'b1, 32'h080, 1'b1, 32'h480};

    // Reset state, checked while reset is held and once it is released.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_idle_outputs("in_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_outputs("after_reset");

    for (int i = 0; i < 15; i++) do_access(vt[i]);

    // Reset during ALLOCATE followed by a stray ack.
    mem_auto = 1'b0;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1;
    cpu_we_i  = 1'b0;
    cpu_addr_i = 32'h0000_0500;
    @(negedge clk_i);
    chk("rst_seq_miss_stall", cpu_stall_o, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_seq_alloc_req", mem_req_o, 1'b1);
    chk("rst_seq_alloc_we", mem_we_o, 1'b0);
    chk("rst_seq_alloc_addr", mem_addr_o, 32'h0000_0500);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk_i);
    chk_idle_outputs("post_rst");
    @(posedge clk_i); #1;
    stray_ack = 1'b0;
    @(negedge clk_i);
    chk("stray_ack_memreq", mem_req_o, 1'b0);
    chk("stray_ack_stall", cpu_stall_o, 1'b0);
    txn_q.delete();
    mem_auto = 1'b1;

    // Both the abandoned address and a line valid before reset must miss again.
    do_access('{1'b0, 32'h0000_0500, 32'h0, 0, 2, 1'b0, 32'h0, 1'b1, 32'h500});
    do_access('{1'b0, 32'h0000_0104, 32'h0, 0, 2, 1'b0, 32'h0, 1'b1, 32'h100});

    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    chk("final_idle_rdata", cpu_rdata_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage (EX_MEM address/store data, MEM_WB load data) and the off-chip data memory.
- Hits complete in the access cycle.
- Misses raise a stall that freezes the whole pipeline until the line is written back (if dirty) and refilled over a req/ack block interface.

Parameters:
- LINES, 32, number of cache lines (power of two).
- BLOCK_W, 256, line width in bits (32 bytes, 8 words).
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store word, 0 = load word.
- cpu_addr_i  in  32  byte address (ALU result).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data to MEM_WB.
- cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM; bubble MEM_WB.
- mem_req_o  out  1  memory transaction request.
- mem_we_o  out  1  1 = block write-back, 0 = block fetch.
- mem_addr_o  out  32  block-aligned address, low 5 bits always 0.
- mem_wdata_o  out  256  evicted line.
- mem_rdata_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle pulse: transaction complete.

Behaviour:
- Address split: tag = addr[31:10] (22 b), index = addr[9:5], word = addr[4:2]; addr[1:0] ignored.
- Per line: valid, dirty, tag, 256-bit data. hit = cpu_req_i & valid[index] & (tag match).
- Reset (rst_i high at clk edge):
  - all valid and dirty bits cleared; data/tag arrays not cleared; FSM -> IDLE.
  - Outputs after reset: cpu_stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0.
- Reset mid-transaction: transaction is abandoned; mem_req_o is low the cycle after the reset edge; a late mem_ack_i is ignored.
- IDLE:
  - Load hit: cpu_rdata_o = selected word combinationally, same cycle; cpu_stall_o=0.
  - Store hit: selected word written and dirty set at the clock edge; cpu_stall_o=0.
  - No request: cpu_stall_o=0, cpu_rdata_o=0.
  - Miss: cpu_stall_o=1 combinationally in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o = victim line.
  - Held stable until mem_ack_i, then -> ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 5'b0}; held until mem_ack_i.
  - On ack: line <= mem_rdata_i, tag updated, valid=1, dirty=0. Then -> REFILL.
- REFILL (1 cycle): mem_req_o=0; the access replays as a hit and completes as in IDLE; cpu_stall_o=0; -> IDLE.
- cpu_stall_o=1 in WRITEBACK and ALLOCATE. Miss latency = 1 + ack cycles of each transaction + 1.
- The CPU holds cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i stable while cpu_stall_o=1. A change during a stall is undefined.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored. An ack in the first cycle of a state is legal (minimum 1-cycle transaction).
- In a store miss, the line is refilled first and the word is merged in REFILL, leaving the line dirty.
- Index wrap: none. Conflict misses evict unconditionally.

Decomposition:
- Shared package dcache_pkg:
  - TAG_W=22, IDX_W=5, OFS_W=5, WORD_SEL_W=3.
  - State enum {IDLE, WRITEBACK, ALLOCATE, REFILL}.
  - Field-extract functions for tag/index/word.
- Sub-module dcache_sram:
  - Holds the tag/valid/dirty/data arrays.
  - Combinational read by index; synchronous write of a full line or a single word with dirty/valid update.
- The controller keeps the FSM, hit logic and memory interface.

Test Plan:
- Cold load 0x0000_0040 after reset, memory acks after 3 cycles with word1 = 0xDEAD_BEEF -> stall high 5 cycles; mem_addr_o=0x40 with we=0; then rdata=0xDEADBEEF with no stall.
- Store 0x1234_5678 to 0x44 (hit), then load 0x44 -> no stall on either; rdata=0x12345678; line 2 dirty.
- Load 0x0000_0444 (same index 2, tag 1) -> WRITEBACK with mem_addr_o=0x40, mem_we_o=1, word1 of mem_wdata_o=0x12345678; then ALLOCATE with mem_addr_o=0x440.
- Four back-to-back load hits on four different lines -> cpu_stall_o stays 0 and mem_req_o stays 0 throughout.
- Assert rst_i during ALLOCATE, then a stray mem_ack_i the following cycle -> state IDLE, mem_req_o=0; re-access of the same address misses again.
- Store miss to clean line 0x88 with ack latency 1 -> no WRITEBACK; after REFILL the line is dirty and holds the stored word.
